// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and helpers for the FIFO burst reader
package fifo_rd_pkg;
  localparam int BC_W = 16;
  typedef enum logic {IDLE, BURST} rd_state_e;
  function automatic int min_level(input int level, input int burst_len);
    return level < burst_len ? level : burst_len;
  endfunction
endpackage

// File: rtl/fifo_rd_out_reg.sv
// fifo_rd_out_reg: single-entry valid/ready output register carrying data and last
module fifo_rd_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  accept,
  output logic                  can_load
);
  assign accept   = valid && ready;
  assign can_load = !valid || ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (accept) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a first-word-fall-through FIFO into bounded valid/ready bursts
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 64,
  parameter int TO_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH-1:0] fifo_count,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [BC_W-1:0]       burst_count
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = TO_WIDTH > 0 ? TO_WIDTH : 1;
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  rd_state_e     state;
  logic [LW-1:0] level, beats_left;
  logic [TW-1:0] to_cnt;
  logic          start, accept, can_load;
  // the count port wraps to 0 when full, so full maps to the true depth
  assign level    = fifo_full ? LW'(FIFO_DEPTH) : LW'(fifo_count);
  assign start    = level >= LW'(BURST_LEN)
                 || (TIMEOUT != 0 && to_cnt == TO_LAST && !fifo_empty)
                 || (flush && !fifo_empty);
  assign fifo_ren = rst_n && state == BURST && beats_left != '0 && can_load;
  assign busy     = rst_n && state == BURST;
  fifo_rd_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (fifo_ren),
    .load_data(fifo_rdata),
    .load_last(beats_left == LW'(1)),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .last     (m_last),
    .accept   (accept),
    .can_load (can_load)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      beats_left  <= '0;
      to_cnt      <= '0;
      burst_count <= '0;
    end else if (state == IDLE) begin
      to_cnt <= fifo_empty ? '0 : to_cnt == TO_MAX ? to_cnt : to_cnt + 1'b1;
      if (start) begin
        beats_left <= LW'(min_level(int'(level), BURST_LEN));
        state      <= BURST;
      end
    end else begin
      if (fifo_ren) beats_left <= beats_left - 1'b1;
      if (accept && m_last) begin
        state       <= IDLE;
        to_cnt      <= '0;
        burst_count <= burst_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: table-driven bench with a queue model of the FIFO and a stream monitor
module tb_fifo_burst_reader;
  import fifo_rd_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, m_ready = 1'b1;
  logic        fifo_ren, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] burst_count;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_empty = 1'b1, fifo_full = 1'b0;
  logic [4:0]  fifo_count = 5'd0;
  always #5 clk = ~clk;
  fifo_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .burst_count(burst_count)
  );
  // FIFO model: bulk writes land in one cycle so the full/wrapped-count case is reachable
  logic [7:0] q[$];
  int         bulk_n = 0, ren_empty_err = 0;
  logic [7:0] bulk_base = 8'h00;
  logic       fifo_clr = 1'b0;
  always @(posedge clk) begin
    assert (!(rst_n && fifo_ren && fifo_empty)) else begin
      $display("FAIL ren_while_empty: fifo_ren=1 while fifo_empty=1 at %0t", $time);
      ren_empty_err++;
    end
    if (fifo_clr) q.delete();
    else begin
      if (fifo_ren && q.size() > 0) void'(q.pop_front());
      for (int i = 0; i < bulk_n; i++) q.push_back(bulk_base + 8'(i));
    end
    fifo_empty <= q.size() == 0;
    fifo_full  <= q.size() == 32;
    fifo_count <= 5'(q.size());
    fifo_rdata <= q.size() > 0 ? q[0] : 8'h00;
  end
  logic [15:0] rdy_pat = 16'hFFFF;
  int          ridx = 0;
  always @(posedge clk) begin
    #1;
    m_ready = rdy_pat[ridx];
    ridx = (ridx + 1) % 16;
  end
  logic       mon_clr = 1'b0;
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  int         cap_c[$];
  int         cyc = 0, run = 0, max_run = 0, stall_err = 0, pop_stall_err = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      cap_d.delete(); cap_l.delete(); cap_c.delete();
      max_run = 0; stall_err = 0; pop_stall_err = 0;
    end
    if (rst_n && m_valid && m_ready) begin
      cap_d.push_back(m_data); cap_l.push_back(m_last); cap_c.push_back(cyc);
    end
    run = (rst_n && fifo_ren) ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (rst_n && fifo_ren && m_valid && !m_ready) pop_stall_err++;
    if (rst_n && prev_v && !prev_r && !(m_valid && m_data == prev_d && m_last == prev_l)) stall_err++;
    prev_v = rst_n && m_valid; prev_r = m_ready; prev_d = m_data; prev_l = m_last;
  end
  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic clr_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask
  task automatic load(input int n, input logic [7:0] base);
    @(posedge clk); #1 bulk_n = n; bulk_base = base;
    @(posedge clk); #1 bulk_n = 0;
  endtask
  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask
  // expected stream: base, base+1, ... with last every 8th beat and on the final one
  task automatic collect(input string tag, input int n, input logic [7:0] base, input int exp_run,
                         input int exp_span, input int bc0, input int bursts);
    int err = 0;
    for (int i = 0; i < 3000 && cap_d.size() < n; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".beats"}, cap_d.size(), n);
    for (int i = 0; i < n && i < cap_d.size(); i++)
      if (cap_d[i] != base + 8'(i) || cap_l[i] != (i % 8 == 7 || i == n - 1)) err++;
    chk({tag, ".data_last"}, err, 0);
    if (exp_run >= 0) chk({tag, ".ren_run"}, max_run, exp_run);
    if (exp_span >= 0 && cap_c.size() == n) chk({tag, ".span"}, cap_c[n-1] - cap_c[0], exp_span);
    chk({tag, ".stall_stable"}, stall_err, 0);
    chk({tag, ".pop_in_stall"}, pop_stall_err, 0);
    chk({tag, ".bursts"}, int'(burst_count - 16'(bc0)), bursts);
    chk({tag, ".fifo_left"}, q.size(), 0);
  endtask
  typedef struct {
    int         n;
    logic [7:0] base;
    logic [15:0] rdy;
    logic       fl;
    int         bursts;
    int         run;
    int         span;
  } vec_t;
  vec_t vt[5];
  initial begin
    int k, b, nl, err, bc0;
    vt[0] = '{8,  8'h10, 16'hFFFF,             1'b0, 1, 8,  7};
    vt[1] = '{8,  8'h00, 16'b1010011010101001, 1'b0, 1, -1, -1};
    vt[2] = '{32, 8'h80, 16'hFFFF,             1'b0, 4, 8,  37};
    vt[3] = '{2,  8'hC0, 16'hFFFF,             1'b1, 1, 2,  1};
    vt[4] = '{16, 8'h40, 16'h5555,             1'b0, 2, -1, -1};
    load(20, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst.ren", fifo_ren, 0);
      chk("rst.valid", m_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.bcnt", burst_count, 0);
    end
    @(posedge clk); #1 fifo_clr = 1'b1;
    @(posedge clk); #1 fifo_clr = 1'b0; rst_n = 1'b1;
    clr_mon();
    pulse_flush();
    b = 0;
    repeat (4) begin @(negedge clk); if (busy) b = 1; end
    chk("flush_empty.busy", b, 0);
    for (int i = 0; i < 5; i++) begin
      clr_mon();
      bc0 = burst_count;
      rdy_pat = vt[i].rdy;
      load(vt[i].n, vt[i].base);
      if (vt[i].fl) pulse_flush();
      collect($sformatf("vec%0d", i), vt[i].n, vt[i].base, vt[i].run, vt[i].span, bc0, vt[i].bursts);
      rdy_pat = 16'hFFFF;
    end
    clr_mon();
    bc0 = burst_count;
    load(3, 8'hA0);
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_ren && k < 200);
    chk("timeout.first_pop", k, 65);
    collect("timeout", 3, 8'hA0, 3, 2, bc0, 1);
    chk("timeout.to_cnt", int'(dut.to_cnt), 0);
    clr_mon();
    load(8, 8'h60);
    for (int i = 0; i < 100 && cap_d.size() < 3; i++) begin @(negedge clk); #1; end
    rst_n = 1'b0;
    nl = 0; err = 0;
    for (int i = 0; i < cap_d.size(); i++) begin
      if (cap_l[i]) nl++;
      if (cap_d[i] != 8'h60 + 8'(i)) err++;
    end
    chk("abort.beats", cap_d.size(), 3);
    chk("abort.data", err, 0);
    chk("abort.no_last", nl, 0);
    @(negedge clk);
    chk("abort.valid", m_valid, 0);
    chk("abort.state", int'(dut.state), int'(IDLE));
    chk("abort.left", q.size(), 5);
    #1 rst_n = 1'b1;
    clr_mon();
    pulse_flush();
    collect("abort_tail", 5, 8'h63, 5, 4, 0, 1);
    chk("ren_while_empty", ren_empty_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
